// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//   Polyphonic voice scheduler between the MIDI decoder and the synth voice
//   bank. Accepted note messages are serialised through one work register
//   plus a depth-1 pending register. Each note operation scans the voices one
//   per cycle, then commits in one cycle. When every voice is busy, the
//   oldest voice is stolen.
//
// Ports
//   clock_50_000_000  in   system clock (single domain)
//   reset_l           in   asynchronous active-low reset
//   message           in   decoded MIDI message {type, data_byte1, data_byte2}
//   message_ready     in   one-cycle strobe, message valid this cycle
//   voice_active      out  per-voice note-held level
//   voice_note        out  per-voice MIDI note number
//   voice_velocity    out  per-voice velocity
//   voice_trigger     out  one-cycle pulse on the voice (re)assigned by a commit
//   busy              out  FSM not idle
//   dropped           out  one-cycle pulse when an accepted message is discarded
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package MIDI;
  typedef enum logic [2:0] {
    NOTE_OFF         = 3'd0,
    NOTE_ON          = 3'd1,
    POLY_PRESSURE    = 3'd2,
    CONTROL_CHANGE   = 3'd3,
    PROGRAM_CHANGE   = 3'd4,
    CHANNEL_PRESSURE = 3'd5,
    PITCH_BEND       = 3'd6,
    SYSTEM           = 3'd7
  } message_type_t;

  typedef struct packed {
    message_type_t message_type;
    logic [6:0]    data_byte1;
    logic [6:0]    data_byte2;
  } message_t;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
endpackage

module voice_allocator #(
  parameter int VOICES    = 4,
  parameter int AGE_WIDTH = 8
) (
  input  logic                     clock_50_000_000,
  input  logic                     reset_l,
  input  MIDI::message_t           message,
  input  logic                     message_ready,
  output logic [VOICES-1:0]        voice_active,
  output logic [VOICES-1:0][6:0]   voice_note,
  output logic [VOICES-1:0][6:0]   voice_velocity,
  output logic [VOICES-1:0]        voice_trigger,
  output logic                     busy,
  output logic                     dropped
);

  localparam int IDX_W = $clog2(VOICES);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_e;
  typedef enum logic [1:0] {OP_NOTE_ON, OP_NOTE_OFF, OP_ALL_OFF} op_e;

  typedef struct packed {
    op_e        op;
    logic [6:0] note;
    logic [6:0] vel;
  } op_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                          state_q, state_d;
  op_t                             work_q, work_d;
  op_t                             pend_q, pend_d;
  logic                            pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]                idx_q, idx_d;

  logic                            match_found_q, match_found_d;
  logic [IDX_W-1:0]                match_idx_q, match_idx_d;
  logic                            free_found_q, free_found_d;
  logic [IDX_W-1:0]                free_idx_q, free_idx_d;
  logic                            old_found_q, old_found_d;
  logic [IDX_W-1:0]                old_idx_q, old_idx_d;
  logic [AGE_WIDTH-1:0]            old_age_q, old_age_d;

  logic [VOICES-1:0]               active_q, active_d;
  logic [VOICES-1:0][6:0]          note_q, note_d;
  logic [VOICES-1:0][6:0]          vel_q, vel_d;
  logic [VOICES-1:0][AGE_WIDTH-1:0] age_q, age_d;
  logic [VOICES-1:0]               trigger_q, trigger_d;
  logic                            dropped_q, dropped_d;

  // ---------------------------------------------------------------------------
  // Message filter: only note on/off and All Notes Off are acted upon.
  // ---------------------------------------------------------------------------
  logic msg_accept;
  op_t  msg_op;

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    msg_accept  = 1'b0;
    msg_op.op   = OP_NOTE_ON;
    msg_op.note = message.data_byte1;
    msg_op.vel  = message.data_byte2;
    if (message_ready) begin
      case (message.message_type)
        MIDI::NOTE_ON:  msg_accept = 1'b1;
        MIDI::NOTE_OFF: begin
          msg_accept = 1'b1;
          msg_op.op  = OP_NOTE_OFF;
        end
        MIDI::CONTROL_CHANGE: begin
          if (message.data_byte1 == MIDI::CC_ALL_NOTES_OFF) begin
            msg_accept = 1'b1;
            msg_op.op  = OP_ALL_OFF;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] target;

  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    idx_d         = idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    active_d      = active_q;
    note_d        = note_q;
    vel_d         = vel_q;
    age_d         = age_q;
    trigger_d     = '0;
    dropped_d     = 1'b0;
    target        = '0;

    case (state_q)
      S_IDLE: begin
        // Pending work takes priority; a simultaneous new message refills
        // the pending slot as it is being drained.
        if (pend_valid_q) begin
          work_d       = pend_q;
          pend_valid_d = msg_accept;
          if (msg_accept) pend_d = msg_op;
        end else if (msg_accept) begin
          work_d = msg_op;
        end
        if (pend_valid_q || msg_accept) begin
          state_d       = (work_d.op == OP_ALL_OFF) ? S_COMMIT : S_SCAN;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
        end
      end

      S_SCAN, S_COMMIT: begin
        if (msg_accept) begin
          if (!pend_valid_q) begin
            pend_d       = msg_op;
            pend_valid_d = 1'b1;
          end else begin
            dropped_d = 1'b1;
          end
        end

        if (state_q == S_SCAN) begin
          if (active_q[idx_q]) begin
            if (!match_found_q && note_q[idx_q] == work_q.note) begin
              match_found_d = 1'b1;
              match_idx_d   = idx_q;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (!old_found_q || age_q[idx_q] > old_age_q) begin
              old_found_d = 1'b1;
              old_idx_d   = idx_q;
              old_age_d   = age_q[idx_q];
            end
          end else if (!free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end
          if (idx_q == IDX_W'(VOICES - 1)) state_d = S_COMMIT;
          else                             idx_d   = idx_q + IDX_W'(1);
        end else begin
          state_d = S_IDLE;
          case (work_q.op)
            OP_NOTE_ON: begin
              if (match_found_q)     target = match_idx_q;
              else if (free_found_q) target = free_idx_q;
              else                   target = old_idx_q;
              for (int v = 0; v < VOICES; v++) begin
                if (IDX_W'(v) == target) begin
                  active_d[v]  = 1'b1;
                  note_d[v]    = work_q.note;
                  vel_d[v]     = work_q.vel;
                  age_d[v]     = '0;
                  trigger_d[v] = 1'b1;
                end else if (active_q[v] && age_q[v] != '1) begin
                  age_d[v] = age_q[v] + AGE_WIDTH'(1);
                end
              end
            end
            OP_NOTE_OFF: begin
              for (int v = 0; v < VOICES; v++) begin
                if (active_q[v] && note_q[v] == work_q.note) active_d[v] = 1'b0;
              end
            end
            default: begin
              active_d = '0;
              age_d    = '0;
            end
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the per-voice arrays are a handful of flops, not a RAM, so they are
  // reset along with everything else to give defined outputs after reset.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= S_IDLE;
      work_q        <= '0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      idx_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      active_q      <= '0;
      note_q        <= '0;
      vel_q         <= '0;
      age_q         <= '0;
      trigger_q     <= '0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      idx_q         <= idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      active_q      <= active_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      age_q         <= age_d;
      trigger_q     <= trigger_d;
      dropped_q     <= dropped_d;
    end
  end

  assign voice_active   = active_q;
  assign voice_note     = note_q;
  assign voice_velocity = vel_q;
  assign voice_trigger  = trigger_q;
  assign busy           = (state_q != S_IDLE);
  assign dropped        = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
//   Directed self-checking bench for voice_allocator (VOICES=4).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that
//   same point, clear of the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_voice_allocator;

  logic                clk;
  logic                rst_n;
  MIDI::message_t      message;
  logic                message_ready;
  logic [3:0]          voice_active;
  logic [3:0][6:0]     voice_note;
  logic [3:0][6:0]     voice_velocity;
  logic [3:0]          voice_trigger;
  logic                busy;
  logic                dropped;

  int tests_run    = 0;
  int tests_failed = 0;

  voice_allocator #(.VOICES(4), .AGE_WIDTH(8)) dut (
    .clock_50_000_000 (clk),
    .reset_l          (rst_n),
    .message          (message),
    .message_ready    (message_ready),
    .voice_active     (voice_active),
    .voice_note       (voice_note),
    .voice_velocity   (voice_velocity),
    .voice_trigger    (voice_trigger),
    .busy             (busy),
    .dropped          (dropped)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    message_ready = 1'b0;
    message       = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Strobe one message during cycle c; returns 1 ns into cycle c+1.
  task automatic send(input MIDI::message_type_t t, input logic [6:0] b1, input logic [6:0] b2);
    message.message_type = t;
    message.data_byte1   = b1;
    message.data_byte2   = b2;
    message_ready        = 1'b1;
    tick(1);
    message_ready = 1'b0;
  endtask

  // NOTE_ON and wait until its commit is visible (c+6) and the FSM is idle.
  task automatic play(input logic [6:0] note, input logic [6:0] vel);
    send(MIDI::NOTE_ON, note, vel);
    tick(5);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (voice_active !== 4'b0000 || voice_trigger !== 4'b0000 || busy !== 1'b0 || dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: active=%b trig=%b busy=%b dropped=%b, want 0000 0000 0 0",
               voice_active, voice_trigger, busy, dropped);
    end
    tests_run++;
    if (voice_note !== '0 || voice_velocity !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: note=%h vel=%h, want 0 0", voice_note, voice_velocity);
    end
    // Reset in the middle of a scan must leave nothing committed.
    send(MIDI::NOTE_ON, 7'd50, 7'd50);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midscan_busy: got %b want 0", busy);
    end
    rst_n = 1'b1;
    tick(6);
    tests_run++;
    if (voice_active !== 4'b0000 || voice_trigger !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_midscan_commit: active=%b trig=%b want 0000 0000", voice_active, voice_trigger);
    end
  endtask

  task automatic test_first_note();
    do_reset();
    send(MIDI::NOTE_ON, 7'd60, 7'd100);       // now c+1
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_busy: got %b want 1", busy);
    end
    tick(4);                                   // c+5
    tests_run++;
    if (voice_trigger !== 4'b0000 || voice_active !== 4'b0000) begin
      tests_failed++;
      $display("FAIL first_early: trig=%b active=%b want 0000 0000", voice_trigger, voice_active);
    end
    tick(1);                                   // c+6
    tests_run++;
    if (voice_trigger !== 4'b0001) begin
      tests_failed++;
      $display("FAIL first_trigger: got %b want 0001", voice_trigger);
    end
    tests_run++;
    if (voice_active !== 4'b0001 || voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd100) begin
      tests_failed++;
      $display("FAIL first_voice: active=%b note0=%0d vel0=%0d want 0001 60 100",
               voice_active, voice_note[0], voice_velocity[0]);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_idle: busy=%b want 0", busy);
    end
    tick(1);
    tests_run++;
    if (voice_trigger !== 4'b0000) begin
      tests_failed++;
      $display("FAIL first_trig_pulse: got %b want 0000", voice_trigger);
    end
  endtask

  task automatic test_steal_oldest();
    do_reset();
    play(7'd60, 7'd10);
    play(7'd62, 7'd20);
    play(7'd64, 7'd30);
    play(7'd67, 7'd40);
    tests_run++;
    if (voice_active !== 4'b1111) begin
      tests_failed++;
      $display("FAIL steal_fill: active=%b want 1111", voice_active);
    end
    send(MIDI::NOTE_ON, 7'd72, 7'd90);
    tick(5);
    tests_run++;
    if (voice_trigger !== 4'b0001) begin
      tests_failed++;
      $display("FAIL steal_trigger: got %b want 0001", voice_trigger);
    end
    tests_run++;
    if (voice_note !== {7'd67, 7'd64, 7'd62, 7'd72} || voice_velocity !== {7'd40, 7'd30, 7'd20, 7'd90}) begin
      tests_failed++;
      $display("FAIL steal_voices: note=%h vel=%h want %h %h", voice_note, voice_velocity,
               {7'd67, 7'd64, 7'd62, 7'd72}, {7'd40, 7'd30, 7'd20, 7'd90});
    end
    // Voice 1 is now the oldest (ages 0,3,2,1).
    send(MIDI::NOTE_ON, 7'd74, 7'd91);
    tick(5);
    tests_run++;
    if (voice_trigger !== 4'b0010 || voice_note[1] !== 7'd74) begin
      tests_failed++;
      $display("FAIL steal_second: trig=%b note1=%0d want 0010 74", voice_trigger, voice_note[1]);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    play(7'd10, 7'd11);
    play(7'd20, 7'd21);
    play(7'd60, 7'd100);
    send(MIDI::NOTE_ON, 7'd60, 7'd50);
    tick(5);
    tests_run++;
    if (voice_trigger !== 4'b0100 || voice_active !== 4'b0111) begin
      tests_failed++;
      $display("FAIL retrig_alloc: trig=%b active=%b want 0100 0111", voice_trigger, voice_active);
    end
    tests_run++;
    if (voice_note[2] !== 7'd60 || voice_velocity[2] !== 7'd50) begin
      tests_failed++;
      $display("FAIL retrig_voice: note2=%0d vel2=%0d want 60 50", voice_note[2], voice_velocity[2]);
    end
  endtask

  task automatic test_note_off_free();
    do_reset();
    play(7'd60, 7'd1);
    play(7'd62, 7'd2);
    play(7'd64, 7'd3);
    play(7'd67, 7'd4);
    send(MIDI::NOTE_OFF, 7'd62, 7'd0);
    tick(5);
    tests_run++;
    if (voice_active !== 4'b1101 || voice_trigger !== 4'b0000) begin
      tests_failed++;
      $display("FAIL off_active: active=%b trig=%b want 1101 0000", voice_active, voice_trigger);
    end
    tests_run++;
    if (voice_note[1] !== 7'd62 || voice_velocity[1] !== 7'd2) begin
      tests_failed++;
      $display("FAIL off_retain: note1=%0d vel1=%0d want 62 2", voice_note[1], voice_velocity[1]);
    end
    send(MIDI::NOTE_OFF, 7'd99, 7'd0);
    tick(5);
    tests_run++;
    if (voice_active !== 4'b1101) begin
      tests_failed++;
      $display("FAIL off_nomatch: active=%b want 1101", voice_active);
    end
    send(MIDI::NOTE_ON, 7'd70, 7'd77);
    tick(5);
    tests_run++;
    if (voice_trigger !== 4'b0010 || voice_active !== 4'b1111 || voice_note[1] !== 7'd70 || voice_note[0] !== 7'd60) begin
      tests_failed++;
      $display("FAIL off_free_first: trig=%b active=%b note1=%0d note0=%0d want 0010 1111 70 60",
               voice_trigger, voice_active, voice_note[1], voice_note[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // cycle c
    message.message_type = MIDI::NOTE_ON; message.data_byte1 = 7'd40; message.data_byte2 = 7'd1;
    message_ready = 1'b1;
    tick(1);                                   // c+1
    message.data_byte1 = 7'd41; message.data_byte2 = 7'd2;
    tick(1);                                   // c+2
    message.data_byte1 = 7'd42; message.data_byte2 = 7'd3;
    tests_run++;
    if (dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_no_drop_early: dropped=%b want 0", dropped);
    end
    tick(1);                                   // c+3
    message_ready = 1'b0;
    tests_run++;
    if (dropped !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_dropped: got %b want 1", dropped);
    end
    tick(1);                                   // c+4
    tests_run++;
    if (dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drop_pulse: got %b want 0", dropped);
    end
    tick(2);                                   // c+6
    tests_run++;
    if (voice_active !== 4'b0001 || voice_note[0] !== 7'd40 || voice_trigger !== 4'b0001) begin
      tests_failed++;
      $display("FAIL b2b_first: active=%b note0=%0d trig=%b want 0001 40 0001",
               voice_active, voice_note[0], voice_trigger);
    end
    tick(6);                                   // c+12
    tests_run++;
    if (voice_active !== 4'b0011 || voice_note[1] !== 7'd41 || voice_trigger !== 4'b0010) begin
      tests_failed++;
      $display("FAIL b2b_second: active=%b note1=%0d trig=%b want 0011 41 0010",
               voice_active, voice_note[1], voice_trigger);
    end
    tick(8);
    tests_run++;
    if (voice_active !== 4'b0011 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_third_discarded: active=%b busy=%b want 0011 0", voice_active, busy);
    end
  endtask

  task automatic test_all_notes_off();
    do_reset();
    play(7'd60, 7'd1);
    play(7'd62, 7'd2);
    play(7'd64, 7'd3);
    play(7'd67, 7'd4);
    send(MIDI::CONTROL_CHANGE, 7'd123, 7'd0);  // c+1
    tests_run++;
    if (busy !== 1'b1 || voice_active !== 4'b1111) begin
      tests_failed++;
      $display("FAIL cc123_commit: busy=%b active=%b want 1 1111", busy, voice_active);
    end
    tick(1);                                   // c+2
    tests_run++;
    if (voice_active !== 4'b0000 || voice_trigger !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL cc123_clear: active=%b trig=%b busy=%b want 0000 0000 0",
               voice_active, voice_trigger, busy);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    play(7'd60, 7'd100);
    send(MIDI::PROGRAM_CHANGE, 7'd5, 7'd0);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (busy !== 1'b0 || dropped !== 1'b0) begin
        tests_failed++;
        $display("FAIL pc_ignored_%0d: busy=%b dropped=%b want 0 0", i, busy, dropped);
      end
      tick(1);
    end
    send(MIDI::CONTROL_CHANGE, 7'd7, 7'd64);
    tick(6);
    tests_run++;
    if (voice_active !== 4'b0001 || voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd100 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_unchanged: active=%b note0=%0d vel0=%0d busy=%b want 0001 60 100 0",
               voice_active, voice_note[0], voice_velocity[0], busy);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    message_ready = 1'b0;
    message       = '0;
    test_reset();
    test_first_note();
    test_steal_oldest();
    test_retrigger();
    test_note_off_free();
    test_back_to_back();
    test_all_notes_off();
    test_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
